// File: rtl/iir_biquad_mc.sv
// iir_biquad_mc
//   Time-multiplexed direct-form-I biquad IIR filter for NCH channels.
//   One signed multiplier is shared by the five taps of every channel.
//   Each accepted sample takes 5 multiply-accumulate cycles and 1 round/saturate cycle.
//   Every channel keeps its own coefficients and its own x/y history.
// Ports
//   clk, reset              clock; asynchronous active-high reset
//   cfg_we/ch/sel/data      coefficient write (sel 0=b0 1=b1 2=b2 3=a1 4=a2)
//   clr_state               clears all history and sat_sticky, and aborts an in-flight sample
//   in_valid/ready/ch/data  sample input handshake (in_ready is combinational)
//   out_valid/ch/data       one-cycle result pulse; out_ch/out_data hold their values between pulses
//   busy                    a sample is in flight
//   cfg_err                 one-cycle pulse after a coefficient write is dropped
//   sat_sticky              set when any output saturates
//
// state | meaning
// IDLE  | waiting for a sample or a coefficient write
// MAC   | one tap per cycle: b0*x, b1*x1, b2*x2, -a1*y1, -a2*y2
// RND   | round, saturate, write the output and update the history
module iir_biquad_mc #(
  parameter int DW   = 8,
  parameter int CW   = 16,
  parameter int FRAC = 14,
  parameter int NCH  = 4,
  parameter int CHW  = $clog2(NCH)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           cfg_we,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [2:0]     cfg_sel,
  input  logic [CW-1:0]  cfg_data,
  input  logic           clr_state,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [CHW-1:0] in_ch,
  input  logic [DW-1:0]  in_data,
  output logic           out_valid,
  output logic [CHW-1:0] out_ch,
  output logic [DW-1:0]  out_data,
  output logic           busy,
  output logic           cfg_err,
  output logic           sat_sticky
);
  localparam int ACCW = DW + CW + 3;
  localparam int PW   = DW + CW;
  localparam logic signed [ACCW-1:0] HALF = ACCW'(2 ** (FRAC - 1));
  localparam logic signed [ACCW-1:0] SMAX = ACCW'(2 ** (DW - 1) - 1);
  localparam logic signed [ACCW-1:0] SMIN = -SMAX - ACCW'(1);

  typedef enum logic [1:0] {IDLE, MAC, RND} state_t;
  state_t state, state_nxt;

  logic signed [CW-1:0]   coef [NCH-1:0][0:4];
  logic signed [DW-1:0]   x1 [NCH-1:0];
  logic signed [DW-1:0]   x2 [NCH-1:0];
  logic signed [DW-1:0]   y1 [NCH-1:0];
  logic signed [DW-1:0]   y2 [NCH-1:0];

  logic [2:0]             tap;
  logic [CHW-1:0]         cur_ch;
  logic signed [DW-1:0]   cur_x;
  logic signed [ACCW-1:0] acc;

  logic                   accept;
  logic                   cfg_ok;
  logic signed [CW-1:0]   mul_c;
  logic signed [DW-1:0]   mul_d;
  logic signed [PW-1:0]   prod;
  logic signed [ACCW-1:0] prod_ext;
  logic signed [ACCW-1:0] acc_rnd;
  logic signed [ACCW-1:0] acc_sh;
  logic                   sat_hi;
  logic                   sat_lo;
  logic signed [DW-1:0]   y_sat;

  assign in_ready = (state == IDLE) && !cfg_we && !clr_state;
  assign accept   = in_valid && in_ready;
  assign busy     = (state != IDLE);
  assign cfg_ok   = cfg_we && (state == IDLE) && !clr_state && (cfg_sel <= 3'd4);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = MAC;
      MAC:     if (tap == 3'd4) state_nxt = RND;
      RND:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (clr_state) state_nxt = IDLE;
  end

  // Shared multiplier operand selection
  always_comb begin
    mul_c = '0;
    mul_d = '0;
    case (tap)
      3'd0: begin mul_c = coef[cur_ch][0]; mul_d = cur_x;      end
      3'd1: begin mul_c = coef[cur_ch][1]; mul_d = x1[cur_ch]; end
      3'd2: begin mul_c = coef[cur_ch][2]; mul_d = x2[cur_ch]; end
      3'd3: begin mul_c = coef[cur_ch][3]; mul_d = y1[cur_ch]; end
      3'd4: begin mul_c = coef[cur_ch][4]; mul_d = y2[cur_ch]; end
      default: ;
    endcase
  end

  assign prod     = mul_c * mul_d;
  assign prod_ext = ACCW'(prod);

  // Round half up, then arithmetic shift keeps the full width so the saturation compare sees every bit
  assign acc_rnd = acc + HALF;
  assign acc_sh  = acc_rnd >>> FRAC;
  assign sat_hi  = acc_sh > SMAX;
  assign sat_lo  = acc_sh < SMIN;
  assign y_sat   = sat_hi ? {1'b0, {(DW-1){1'b1}}} :
                   sat_lo ? {1'b1, {(DW-1){1'b0}}} : acc_sh[DW-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tap        <= '0;
      cur_ch     <= '0;
      cur_x      <= '0;
      acc        <= '0;
      out_valid  <= 1'b0;
      out_ch     <= '0;
      out_data   <= '0;
      cfg_err    <= 1'b0;
      sat_sticky <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        x1[c] <= '0;
        x2[c] <= '0;
        y1[c] <= '0;
        y2[c] <= '0;
        for (int t = 0; t < 5; t++) coef[c][t] <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      cfg_err   <= cfg_we && !cfg_ok;
      if (cfg_ok) begin
        for (int t = 0; t < 5; t++)
          if (cfg_sel == 3'(t)) coef[cfg_ch][t] <= cfg_data;
      end
      if (clr_state) begin
        sat_sticky <= 1'b0;
        for (int c = 0; c < NCH; c++) begin
          x1[c] <= '0;
          x2[c] <= '0;
          y1[c] <= '0;
          y2[c] <= '0;
        end
      end else begin
        case (state)
          IDLE: if (accept) begin
            cur_ch <= in_ch;
            cur_x  <= in_data;
            acc    <= '0;
            tap    <= '0;
          end
          MAC: begin
            // Feedback taps are subtracted
            acc <= (tap < 3'd3) ? acc + prod_ext : acc - prod_ext;
            tap <= tap + 3'd1;
          end
          RND: begin
            out_valid  <= 1'b1;
            out_ch     <= cur_ch;
            out_data   <= y_sat;
            x2[cur_ch] <= x1[cur_ch];
            x1[cur_ch] <= cur_x;
            y2[cur_ch] <= y1[cur_ch];
            y1[cur_ch] <= y_sat;
            if (sat_hi || sat_lo) sat_sticky <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end
endmodule
